// File: rtl/axi_rd_burst_bridge.sv
// axi_rd_burst_bridge
//
// Takes one read request at a time from the Dcache prefetcher and turns it
// into AXI4 INCR read bursts on the crossbar read channel. Incoming 32-bit
// beats are packed into a 256-bit return word.
//
// Request types:
//   00 = uncached word (1 beat)
//   01 = one 16-byte line (4 beats); 11 is handled the same way
//   10 = two consecutive lines (8 beats)
//
// A type-10 request whose second line starts on a new 4KB page is split into
// two 4-beat bursts, because an INCR burst must not cross a 4KB boundary.
//
// Ports:
//   clk, resetn          clock (rising edge) and async active-low reset
//   axi_rd_req/type/addr request from the prefetcher
//   axi_rd_rdy           high while idle; a request is taken when req && rdy
//   axi_ret_valid        one-cycle pulse when the transfer is complete
//   axi_ret_half         one-cycle pulse when the first line of a type-10
//                        transfer is complete
//   axi_ret_data         assembled return data
//   rd_err               sticky flag for a bad response or an rlast mismatch
//   ar*/arvalid/arready  AXI read address channel
//   r*/rvalid/rready     AXI read data channel (rid is ignored)
module axi_rd_burst_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         axi_rd_req,
  input  logic [1:0]   axi_rd_type,
  input  logic [31:0]  axi_rd_addr,
  output logic         axi_rd_rdy,
  output logic         axi_ret_valid,
  output logic [255:0] axi_ret_data,
  output logic         axi_ret_half,
  output logic         rd_err,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [3:0]   arid,
  output logic [3:0]   arcache,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    ADDR2 = 3'd3,
    DATA2 = 3'd4
  } state_t;

  state_t         state_reg;
  logic           word_reg;   // type 00 transfer
  logic           dbl_reg;    // type 10 transfer
  logic           split_reg;  // type 10 issued as two 4-beat bursts
  logic [2:0]     cnt_reg;    // beat index, runs across both bursts of a split
  logic [31:0]    araddr_reg;
  logic [7:0]     arlen_reg;
  logic [3:0]     arcache_reg;
  logic           arvalid_reg;
  logic [255:0]   data_reg;
  logic           ret_valid_reg;
  logic           ret_half_reg;
  logic           rd_err_reg;

  logic           beat;
  logic [2:0]     last_idx;
  logic           is_final;
  logic           last_expected;
  logic           split_req;

  assign axi_rd_rdy    = (state_reg == IDLE);
  assign rready        = (state_reg == DATA) || (state_reg == DATA2);
  assign arsize        = 3'b010;
  assign arburst       = 2'b01;
  assign arid          = AXI_ID;
  assign araddr        = araddr_reg;
  assign arlen         = arlen_reg;
  assign arcache       = arcache_reg;
  assign arvalid       = arvalid_reg;
  assign axi_ret_data  = data_reg;
  assign axi_ret_valid = ret_valid_reg;
  assign axi_ret_half  = ret_half_reg;
  assign rd_err        = rd_err_reg;

  assign beat     = rvalid && rready;
  assign last_idx = word_reg ? 3'd0 : (dbl_reg ? 3'd7 : 3'd3);
  assign is_final = (cnt_reg == last_idx);
  // The slave should flag rlast at the end of every burst it was given,
  // which for a split transfer includes beat 3.
  assign last_expected = is_final || (split_reg && (cnt_reg == 3'd3));
  // The second line would start on the next 4KB page.
  assign split_req = (axi_rd_type == 2'b10) && (axi_rd_addr[11:4] == 8'hFF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      word_reg      <= 1'b0;
      dbl_reg       <= 1'b0;
      split_reg     <= 1'b0;
      cnt_reg       <= 3'd0;
      araddr_reg    <= 32'd0;
      arlen_reg     <= 8'd0;
      arcache_reg   <= 4'd0;
      arvalid_reg   <= 1'b0;
      data_reg      <= 256'd0;
      ret_valid_reg <= 1'b0;
      ret_half_reg  <= 1'b0;
      rd_err_reg    <= 1'b0;
    end else begin
      ret_valid_reg <= 1'b0;
      ret_half_reg  <= 1'b0;

      // Completion follows the beat count; rlast is only cross-checked.
      if (beat && ((rlast != last_expected) || (rresp != 2'b00))) begin
        rd_err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (axi_rd_req) begin
            word_reg    <= (axi_rd_type == 2'b00);
            dbl_reg     <= (axi_rd_type == 2'b10);
            split_reg   <= split_req;
            cnt_reg     <= 3'd0;
            arvalid_reg <= 1'b1;
            state_reg   <= ADDR;
            case (axi_rd_type)
              2'b00: begin
                araddr_reg  <= axi_rd_addr & 32'hFFFF_FFFC;
                arlen_reg   <= 8'd0;
                arcache_reg <= 4'b0000;
              end
              2'b10: begin
                araddr_reg  <= axi_rd_addr & 32'hFFFF_FFF0;
                arlen_reg   <= split_req ? 8'd3 : 8'd7;
                arcache_reg <= 4'b1111;
              end
              default: begin
                araddr_reg  <= axi_rd_addr & 32'hFFFF_FFF0;
                arlen_reg   <= 8'd3;
                arcache_reg <= 4'b1111;
              end
            endcase
          end
        end

        ADDR, ADDR2: begin
          if (arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= (state_reg == ADDR) ? DATA : DATA2;
          end
        end

        DATA, DATA2: begin
          if (beat) begin
            if (word_reg) begin
              data_reg <= {224'd0, rdata};
            end else begin
              data_reg[{cnt_reg, 5'b00000} +: 32] <= rdata;
            end
            cnt_reg <= cnt_reg + 3'd1;
            if (dbl_reg && (cnt_reg == 3'd3)) begin
              ret_half_reg <= 1'b1;
            end
            if (is_final) begin
              ret_valid_reg <= 1'b1;
              state_reg     <= IDLE;
            end else if (split_reg && (state_reg == DATA) && (cnt_reg == 3'd3)) begin
              // Second burst starts on the next page; length stays 3.
              araddr_reg  <= araddr_reg + 32'd16;
              arvalid_reg <= 1'b1;
              state_reg   <= ADDR2;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_burst_bridge.md
Name: axi_rd_burst_bridge

Overview:
Downstream neighbour of the Dcache read prefetcher. Accepts one read request at a time on the prefetcher-side interface (type 00 = uncached word, 01 = one 16-byte line, 10 = two consecutive lines), issues AXI4 INCR read bursts and assembles the beats into a 256-bit return word. Raises a half-done pulse after the first line and a done pulse after the last beat. Sits between the prefetcher and the core's AXI crossbar read channel.

Parameters:
AXI_ID, 4'd1, constant driven on arid; rid is not checked.

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  reset; asynchronous, active-low
axi_rd_req  in  1  read request valid
axi_rd_type  in  2  00 word, 01 line (4 beats), 10 double line (8 beats); 11 treated as 01
axi_rd_addr  in  32  byte address; bits [3:0] ignored for types 01/10
axi_rd_rdy  out  1  request accepted when req&&rdy
axi_ret_valid  out  1  one-cycle pulse, transfer complete
axi_ret_data  out  256  assembled data
axi_ret_half  out  1  one-cycle pulse, first line ([127:0]) complete, type 10 only
rd_err  out  1  sticky: SLVERR/DECERR or rlast/count mismatch seen
araddr  out  32  AXI read address
arlen  out  8  beats-1
arsize  out  3  always 3'b010
arburst  out  2  always 2'b01 (INCR)
arid  out  4  AXI_ID
arcache  out  4  4'b0000 for type 00, 4'b1111 otherwise
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  read data beat
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (async assert, deasserted synchronously by the environment): state IDLE; arvalid, rready, axi_ret_valid, axi_ret_half, rd_err = 0; axi_ret_data = 0; beat counter = 0.
- axi_rd_rdy = (state==IDLE), combinational. One transaction outstanding, never more.
- States: IDLE, ADDR, DATA, ADDR2, DATA2.
- IDLE: on req&&rdy latch type and address. Type 00: araddr = addr with [1:0]=0, arlen=0. Type 01: araddr = {addr[31:4],4'b0}, arlen=3. Type 10 with addr[11:4]!=8'hFF: single burst, arlen=7. Type 10 with addr[11:4]==8'hFF (second line crosses a 4KB page): split into two 4-beat bursts, second at araddr+16. Next state ADDR; arvalid=1 from next cycle.
- ADDR/ADDR2: hold arvalid and all AR fields stable until arready; on handshake arvalid drops next cycle, go DATA/DATA2.
- DATA/DATA2: rready=1. Each rvalid&&rready beat writes rdata into axi_ret_data[32*cnt +: 32], cnt increments (3 bits, counts across both bursts of a split). Type 00: bits [255:32] cleared on that beat.
- After beat index 3 of type 10, axi_ret_half pulses high the following cycle (also when the split boundary falls there).
- Split case: beat index 3 ends DATA -> ADDR2 (second burst).
- Final beat (index 0/3/7 for type 00/01/10) -> IDLE; axi_ret_valid pulses the following cycle, coinciding with the first IDLE cycle. axi_ret_data holds until the next R beat (earliest 2 cycles later).
- Completion is decided by the counter, not rlast. rlast asserted on a non-final beat, or absent on the final beat -> rd_err set; transfer still completes on count. Any rresp!=00 -> rd_err set. rd_err clears only on reset.
- Type 10: ret_half and ret_valid never in the same cycle. Types 00/01: ret_half never asserted.
- Reset mid-transfer: everything returns to reset values immediately; no completion pulse. The interconnect is reset on the same net.

Test Plan:
- Type 00, addr 0xBFAF_0003, arready immediate, rdata 0x1234_5678 -> araddr 0xBFAF_0000, arlen 0, arcache 0; ret_valid pulse 1 cycle after beat; ret_data = 0x...0000_1234_5678; no ret_half.
- Type 01, addr 0x0000_1A2C, beats 0x11,0x22,0x33,0x44 -> araddr 0x1A20, arlen 3; ret_data[127:0] = 0x44_33_22_11 words; ret_valid once, ret_half never.
- Type 10, addr 0x0000_2040, 8 beats 1..8, rvalid gaps of 2 cycles -> one burst arlen 7; ret_half 1 cycle after beat 4 ([127:0]=4,3,2,1); ret_valid 1 cycle after beat 8 ([255:128]=8,7,6,5).
- Type 10, addr 0x0000_3FF0 -> two ARs: 0x3FF0 arlen 3, then 0x4000 arlen 3; ret_half after first burst; ret_valid after second; rd_err stays 0.
- arready held low 5 cycles with new req pending -> AR fields stable, axi_rd_rdy=0 throughout; second request accepted in the ret_valid cycle.
- Type 01 with rlast on beat 2 and rresp=2'b10 on beat 1 -> rd_err=1 sticky; completion still after beat 4; assert resetn low mid-DATA -> all outputs 0, state IDLE.
